prog_data_mem: RTL and testbench

//  Parametrised unified program/data memory for the 8-bit microprocessor; replaces the fixed 16x8 ROM.

---
 rtl/prog_data_mem.sv | 105 ++++++++++
 tb/tb_prog_data_mem.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/prog_data_mem.sv
// Unified program/data memory: boot image reloaded after every reset, registered reads
// with READ_LAT-deep pipeline, write path with an optional write-protected program region.
//
// state | meaning
// INIT  | copying boot image into mem[init_ptr], requests ignored, ready=0
// IDLE  | image loaded, ready=1, one read or write accepted per cycle
module prog_data_mem #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int PROG_WORDS = 8,
  parameter int PROTECT    = 1,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              err_clr,
  output logic              ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              wr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t                            state_q, state_d;
  logic [ADDR_W-1:0]                 init_ptr;
  logic [DATA_W-1:0]                 mem [DEPTH];
  logic                              rd_acc, wr_acc, prot_hit;
  logic [READ_LAT-1:0]               vld;
  logic [READ_LAT-1:0][DATA_W-1:0]   dat;

  function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] a);
    case (32'(a))
      0:       boot_word = DATA_W'(8'h08);
      1:       boot_word = DATA_W'(8'hC9);
      2:       boot_word = DATA_W'(8'hEE);
      3:       boot_word = DATA_W'(8'hFF);
      8:       boot_word = DATA_W'(8'h06);
      9:       boot_word = DATA_W'(8'h07);
      default: boot_word = '0;
    endcase
  endfunction

  assign ready    = (state_q == IDLE);
  assign rd_acc   = ready & req & ~we;
  assign wr_acc   = ready & req & we;
  assign prot_hit = (PROTECT != 0) && (32'(addr) < 32'(PROG_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      init_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_ptr == LAST_ADDR) state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Array has no reset; the init FSM rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem[init_ptr] <= boot_word(init_ptr);
    else if (wr_acc && !prot_hit) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else if (wr_acc && prot_hit) wr_err <= 1'b1;
    else if (err_clr) wr_err <= 1'b0;
  end

  // Each stage only loads on a valid beat, so the last stage doubles as the held rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      dat <= '0;
    end else begin
      vld[0] <= rd_acc;
      if (rd_acc) dat[0] <= mem[addr];
      for (int i = 1; i < READ_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign rd_valid = vld[READ_LAT-1];
  assign rdata    = dat[READ_LAT-1];

endmodule

// File: tb/tb_prog_data_mem.sv
// Bench for prog_data_mem: three instances (defaults, READ_LAT=3, PROTECT=0) share one
// stimulus stream and are compared every cycle against an event-scheduled reference model.
module tb_prog_data_mem;

  logic       clk = 1'b0;
  logic       rst, req, we, err_clr;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [2:0] ready, rd_valid, wr_err;
  logic [2:0][7:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_data_mem #(.READ_LAT(1), .PROTECT(1)) u_def (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .err_clr(err_clr),
    .ready(ready[0]), .rd_valid(rd_valid[0]), .rdata(rdata[0]), .wr_err(wr_err[0]));
  prog_data_mem #(.READ_LAT(3), .PROTECT(1)) u_lat3 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .err_clr(err_clr),
    .ready(ready[1]), .rd_valid(rd_valid[1]), .rdata(rdata[1]), .wr_err(wr_err[1]));
  prog_data_mem #(.READ_LAT(1), .PROTECT(0)) u_noprot (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .err_clr(err_clr),
    .ready(ready[2]), .rd_valid(rd_valid[2]), .rdata(rdata[2]), .wr_err(wr_err[2]));

  // reference model: edge counter since reset, memory image, reads scheduled by due cycle
  int         cyc;
  int         cnt [3];
  bit         e_err [3];
  bit         e_vld [3];
  logic [7:0] e_rd [3];
  logic [7:0] mm [3][16];
  bit         sv [3][4];
  logic [7:0] sd [3][4];

  function automatic int lat_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic bit prot_of(input int i);
    return i != 2;
  endfunction

  function automatic logic [7:0] boot(input int a);
    case (a)
      0: return 8'h08;
      1: return 8'hC9;
      2: return 8'hEE;
      3: return 8'hFF;
      8: return 8'h06;
      9: return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; e_err[i] = 0; e_vld[i] = 0; e_rd[i] = 8'h00;
      for (int k = 0; k < 4; k++) sv[i][k] = 0;
      for (int a = 0; a < 16; a++) mm[i][a] = boot(a);
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      e_vld[i] = 0;
      if (!rst) begin
        bit acc, hit;
        int slot;
        acc = (cnt[i] >= 16) && req;
        hit = prot_of(i) && (addr < 4'd8);
        if (acc && we && hit) e_err[i] = 1;
        else if (err_clr) e_err[i] = 0;
        if (acc && we && !hit) mm[i][addr] = wdata;
        if (acc && !we) begin
          slot = (cyc + lat_of(i) - 1) % 4;
          sv[i][slot] = 1;
          sd[i][slot] = mm[i][addr];
        end
        if (cnt[i] < 16) cnt[i]++;
        slot = cyc % 4;
        if (sv[i][slot]) begin
          e_vld[i] = 1;
          e_rd[i] = sd[i][slot];
          sv[i][slot] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(cnt[i] >= 16));
      check($sformatf("rd_valid[%0d]", i), 32'(rd_valid[i]), 32'(e_vld[i]));
      check($sformatf("rdata[%0d]", i), 32'(rdata[i]), 32'(e_rd[i]));
      check($sformatf("wr_err[%0d]", i), 32'(wr_err[i]), 32'(e_err[i]));
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input bit r, input bit w, input logic [3:0] a, input logic [7:0] d,
                      input bit ec);
    req = r; we = w; addr = a; wdata = d; err_clr = ec;
    @(posedge clk);
    model_edge();
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 4'h0, 8'h00, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 0; we = 0; err_clr = 0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 0; we = 0; addr = '0; wdata = '0; err_clr = 0;
    cyc = 0;
    model_reset();
    @(negedge clk);
    #1 compare_all();
    @(negedge clk);
    idle(2);
    rst = 1'b0;

    // requests during init must be ignored (writes land on the upper, unprotected half)
    for (int k = 0; k < 16; k++) step(1, k[0], 4'(8 + k % 8), 8'h5A, 0);

    // boot image reads
    step(1, 0, 4'h0, 8'h00, 0); idle(1);
    step(1, 0, 4'h1, 8'h00, 0); idle(1);
    step(1, 0, 4'h8, 8'h00, 0); idle(1);
    step(1, 0, 4'h9, 8'h00, 0); idle(1);
    step(1, 0, 4'hA, 8'h00, 0); idle(3);

    // STA path, protected write, err_clr
    step(1, 1, 4'hA, 8'h45, 0);
    step(1, 0, 4'hA, 8'h00, 0); idle(3);
    step(1, 1, 4'h2, 8'h55, 0);
    step(1, 0, 4'h2, 8'h00, 0); idle(3);
    step(0, 0, 4'h0, 8'h00, 1); idle(1);

    // back-to-back reads
    step(1, 0, 4'h8, 8'h00, 0);
    step(1, 0, 4'h9, 8'h00, 0);
    step(1, 0, 4'h0, 8'h00, 0); idle(4);

    // err_clr colliding with a fresh protected write: set wins
    step(1, 1, 4'h3, 8'h77, 0);
    step(1, 1, 4'h4, 8'h66, 1);
    step(0, 0, 4'h0, 8'h00, 1); idle(1);

    // write into program region (only the unprotected instance takes it)
    step(1, 1, 4'h0, 8'h12, 0);
    step(1, 0, 4'h0, 8'h00, 0); idle(3);

    // reset with a read in flight, then image restored
    step(1, 1, 4'h9, 8'hAA, 0);
    step(1, 0, 4'h9, 8'h00, 0);
    do_reset();
    idle(16);
    step(1, 0, 4'h9, 8'h00, 0); idle(3);

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
